// File: rtl/hs_pkg.sv
// Shared types and constants for the hs_src traffic source.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Right-shifting Galois LFSR feedback masks giving maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_B400;
      default: lfsr_taps = 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/hs_src_pattern.sv
// Next-beat data generator: +1 by default, Galois LFSR step when HS_SRC_LFSR_EN is defined.
module hs_src_pattern
  import hs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

`ifdef HS_SRC_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  assign nxt = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
`else
  assign nxt = cur + WIDTH'(1);
`endif

endmodule

// File: rtl/hs_src.sv
// Valid/ready burst source: one command in, a burst of beats out, optional idle gap after.
// HS_SRC_LFSR_EN selects LFSR data instead of an incrementing pattern.
module hs_src
  import hs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
  logic             valid_d, last_d, busy_d;
  logic [WIDTH-1:0] data_d, data_nxt, seed_eff;

  hs_src_pattern #(.WIDTH(WIDTH)) u_pattern (
    .cur (o_data),
    .nxt (data_nxt)
  );

`ifdef HS_SRC_LFSR_EN
  // An all-zero LFSR state never leaves zero.
  assign seed_eff = (cmd_seed == '0) ? WIDTH'(1) : cmd_seed;
`else
  assign seed_eff = cmd_seed;
`endif

  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    valid_d = o_valid;
    data_d  = o_data;
    last_d  = o_last;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          gap_d   = cfg_gap;
          cnt_d   = '0;
          data_d  = seed_eff;
          valid_d = 1'b1;
          last_d  = (cmd_len == '0);
          state_d = SEND;
        end
      end
      SEND: begin
        if (o_valid && i_ready) begin
          if (o_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            gcnt_d  = '0;
            state_d = (gap_q != '0) ? GAP : IDLE;
          end else begin
            // cnt_q < len_q here, so cnt_q+1 cannot wrap even at maximum length.
            data_d = data_nxt;
            cnt_d  = cnt_q + LEN_W'(1);
            last_d = ((cnt_q + LEN_W'(1)) == len_q);
          end
        end
      end
      GAP: begin
        gcnt_d = gcnt_q + GAP_W'(1);
        if (gcnt_q == (gap_q - GAP_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      o_valid <= valid_d;
      o_data  <= data_d;
      o_last  <= last_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_hs_src.sv
// Self-checking bench for hs_src: directed bursts plus randomized backpressure against a beat-list model.
module tb_hs_src;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
  localparam int GAP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] cmd_seed;
  logic [GAP_W-1:0] cfg_gap;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_last;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] seen[$];

  hs_src #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_seed  (cmd_seed),
    .cfg_gap   (cfg_gap),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] model_seed(input logic [7:0] s);
`ifdef HS_SRC_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  // Sequence element i of a burst starting at the (fixed-up) seed.
  function automatic logic [7:0] model_beat(input logic [7:0] s, input int i);
`ifdef HS_SRC_LFSR_EN
    logic [7:0] v;
    v = model_seed(s);
    for (int k = 0; k < i; k++) begin
      v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    end
    return v;
`else
    return 8'((int'(s) + i) % 256);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int len, input logic [7:0] seed, input int gap, input bit presented);
    if (!presented) begin
      cmd_len   = len[7:0];
      cmd_seed  = seed;
      cfg_gap   = gap[3:0];
      cmd_valid = 1'b1;
    end
    checkOutput("cmd_ready_at_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runBurst(input int len, input logic [7:0] seed, input int gap, input bit rnd_ready,
                          input bit queue_next, input int nlen, input logic [7:0] nseed, input int ngap);
    logic [7:0] exp_q[$];
    int budget;
    for (int i = 0; i <= len; i++) exp_q.push_back(model_beat(seed, i));
    seen.delete();
    if (queue_next) begin
      cmd_len   = nlen[7:0];
      cmd_seed  = nseed;
      cfg_gap   = ngap[3:0];
      cmd_valid = 1'b1;
    end
    budget = 8 * (len + 1) + 20;
    for (int cyc = 0; cyc < budget && exp_q.size() > 0; cyc++) begin
      checkOutput("o_valid_burst", o_valid, 1);
      checkOutput("o_data", o_data, exp_q[0]);
      checkOutput("o_last", o_last, (exp_q.size() == 1));
      checkOutput("busy_burst", busy, 1);
      checkOutput("cmd_ready_burst", cmd_ready, 0);
      i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i_ready) begin
        seen.push_back(o_data);
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    checkOutput("burst_beats_left", exp_q.size(), 0);
    checkOutput("beat_count", seen.size(), len + 1);
    for (int g = 0; g < gap; g++) begin
      i_ready = 1'($urandom_range(0, 1));
      checkOutput("o_valid_gap", o_valid, 0);
      checkOutput("o_last_gap", o_last, 0);
      checkOutput("cmd_ready_gap", cmd_ready, 0);
      checkOutput("busy_gap", busy, 1);
      @(negedge clk);
    end
    checkOutput("o_valid_after", o_valid, 0);
    checkOutput("o_last_after", o_last, 0);
    checkOutput("cmd_ready_after", cmd_ready, 1);
    checkOutput("busy_after", busy, 0);
  endtask

  initial begin
    logic [7:0] s;
    int l, g;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_seed  = '0;
    cfg_gap   = '0;
    i_ready   = 1'b0;
    #12;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_o_valid", o_valid, 0);
    checkOutput("rst_o_data", o_data, 0);
    checkOutput("rst_o_last", o_last, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst at full throughput, then the same with random backpressure.
    applyStimulus(3, 8'h10, 0, 0);
    runBurst(3, 8'h10, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(3, 8'h10, 0, 0);
    runBurst(3, 8'h10, 0, 1, 0, 0, 8'h00, 0);

    // Data wrap and single-beat burst.
    applyStimulus(2, 8'hFE, 0, 0);
    runBurst(2, 8'hFE, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(0, 8'h5A, 0, 0);
    runBurst(0, 8'h5A, 0, 1, 0, 0, 8'h00, 0);

    // Gap of 5 with the next command held on the bus throughout.
    applyStimulus(4, 8'h20, 5, 0);
    runBurst(4, 8'h20, 5, 1, 1, 2, 8'h80, 0);
    applyStimulus(2, 8'h80, 0, 1);
    runBurst(2, 8'h80, 0, 0, 0, 0, 8'h00, 0);

    for (int n = 0; n < 6; n++) begin
      l = int'($urandom_range(0, 20));
      s = 8'($urandom);
      g = int'($urandom_range(0, 3));
      applyStimulus(l, s, g, 0);
      runBurst(l, s, g, 1, 0, 0, 8'h00, 0);
    end

    // Asynchronous reset in the middle of a burst.
    applyStimulus(9, 8'h40, 0, 0);
    for (int k = 0; k < 3; k++) begin
      i_ready = 1'b1;
      checkOutput("pre_reset_data", o_data, model_beat(8'h40, k));
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_o_valid", o_valid, 0);
    checkOutput("midrst_o_data", o_data, 0);
    checkOutput("midrst_o_last", o_last, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("postrst_o_valid", o_valid, 0);
      checkOutput("postrst_busy", busy, 0);
    end
    applyStimulus(1, 8'h33, 0, 0);
    runBurst(1, 8'h33, 0, 0, 0, 0, 8'h00, 0);

    // Maximum-length burst: exactly 256 beats.
    applyStimulus(255, 8'h00, 0, 0);
    runBurst(255, 8'h00, 0, 0, 0, 0, 8'h00, 0);
`ifdef HS_SRC_LFSR_EN
    begin
      bit hit[256];
      int dup;
      dup = 0;
      foreach (hit[i]) hit[i] = 1'b0;
      for (int i = 0; i < 255 && i < seen.size(); i++) begin
        if (hit[seen[i]] || seen[i] == 8'h00) dup++;
        hit[seen[i]] = 1'b1;
      end
      checkOutput("lfsr_first", seen[0], 8'h01);
      checkOutput("lfsr_distinct_nonzero", dup, 0);
      checkOutput("lfsr_repeat", seen[255], 8'h01);
    end
`else
    checkOutput("max_first", seen[0], 8'h00);
    checkOutput("max_final", seen[255], 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
